operand_fetch: RTL and testbench

//  Decode-side master of i_regbus: drives the two regfile read ports and resolves source operands.

---
 rtl/operand_fetch_pkg.sv | 46 ++++
 rtl/i_regbus.sv | 13 +
 rtl/operand_fetch_resolve.sv | 42 ++++
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared register-bus types for the decode/operand-fetch slice, plus the
// ID/EX pipeline record and a source/producer address-match helper.
package operand_fetch_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam logic REG_ENABLE  = 1'b1;
  localparam logic REG_DISABLE = 1'b0;

  typedef enum logic {
    RST_DISABLE = 1'b0,
    RST_ENABLE  = 1'b1
  } reset_status_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } reg_info_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_t;

  typedef struct packed {
    logic      valid;
    reg_data_t op1;
    reg_data_t op2;
    reg_t      dest;
    logic      is_load;
  } idex_t;

  // Empty ID/EX slot used for reset, flush and hazard bubbles.
  localparam idex_t IDEX_BUBBLE = '0;

  // True when an enabled, non-$0 source reads the register a producer writes.
  function automatic logic addr_match(input reg_info_t src, input reg_t wr);
    return src.en && (src.addr != '0) && wr.en && (wr.addr == src.addr);
  endfunction

endpackage

// File: rtl/i_regbus.sv
// Register-file read bus: two read ports, address/enable out, data back.
interface i_regbus;
  import operand_fetch_pkg::*;

  reg_info_t r1_info;
  reg_info_t r2_info;
  reg_data_t r1_data;
  reg_data_t r2_data;

  modport master (output r1_info, output r2_info, input r1_data, input r2_data);
  modport slave  (input r1_info, input r2_info, output r1_data, output r2_data);

endinterface

// File: rtl/operand_fetch_resolve.sv
// Per-source operand resolution: picks the youngest in-flight producer of the
// source register (EX before MEM before regfile) and flags a hazard when the
// value cannot be supplied this cycle.
module operand_resolve
  import operand_fetch_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  reg_info_t src_i,
  input  reg_data_t rf_data_i,
  input  reg_t      ex_wreg_i,
  input  logic      ex_is_load_i,
  input  reg_t      mem_wreg_i,
  output reg_data_t data_o,
  output logic      hazard_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = addr_match(src_i, ex_wreg_i);
  assign mem_hit = addr_match(src_i, mem_wreg_i);

  // Forwarding mux; $0 and disabled sources always read as zero.
  always_comb begin
    data_o = rf_data_i;
    if (!src_i.en || (src_i.addr == '0)) begin
      data_o = '0;
    end else if (FWD_EN && ex_hit && !ex_is_load_i) begin
      data_o = ex_wreg_i.data;
    end else if (FWD_EN && mem_hit) begin
      data_o = mem_wreg_i.data;
    end
  end

  // With forwarding only a load still in EX is unavailable; without it any
  // pending write in EX or MEM must drain first.
  always_comb begin
    hazard_o = FWD_EN ? (ex_hit && ex_is_load_i) : (ex_hit || mem_hit);
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: drives the regfile read ports, resolves both source operands
// with EX/MEM forwarding, detects load-use hazards and owns the ID/EX register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  reset_status_t    rst,
  input  logic             id_valid,
  input  reg_info_t        id_src1,
  input  reg_info_t        id_src2,
  input  logic             id_use_imm,
  input  reg_data_t        id_imm,
  input  reg_t             id_dest,
  input  logic             id_is_load,
  input  reg_t             ex_wreg,
  input  logic             ex_is_load,
  input  reg_t             mem_wreg,
  input  logic             ex_stall,
  input  logic             flush,
  i_regbus.master          read,
  output logic             stall_req,
  output logic             ex_valid_o,
  output reg_data_t        ex_op1_o,
  output reg_data_t        ex_op2_o,
  output reg_t             ex_dest_o,
  output logic             ex_is_load_o,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  localparam reg_info_t SRC_OFF = '{en: REG_DISABLE, addr: '0};

  reg_info_t        src1_g;
  reg_info_t        src2_g;
  reg_data_t        op1_res;
  reg_data_t        op2_res;
  logic             haz1;
  logic             haz2;
  logic             hazard;
  logic             in_rst;
  idex_t            idex_q;
  idex_t            idex_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Read ports only see a source while a real instruction sits in ID.
  always_comb begin
    src1_g = id_valid ? id_src1 : SRC_OFF;
    src2_g = id_valid ? id_src2 : SRC_OFF;
  end

  assign read.r1_info = src1_g;
  assign read.r2_info = src2_g;

  operand_resolve #(.FWD_EN(FWD_EN)) u_res1 (
    .src_i        (src1_g),
    .rf_data_i    (read.r1_data),
    .ex_wreg_i    (ex_wreg),
    .ex_is_load_i (ex_is_load),
    .mem_wreg_i   (mem_wreg),
    .data_o       (op1_res),
    .hazard_o     (haz1)
  );

  operand_resolve #(.FWD_EN(FWD_EN)) u_res2 (
    .src_i        (src2_g),
    .rf_data_i    (read.r2_data),
    .ex_wreg_i    (ex_wreg),
    .ex_is_load_i (ex_is_load),
    .mem_wreg_i   (mem_wreg),
    .data_o       (op2_res),
    .hazard_o     (haz2)
  );

  // Hazard detection; src2 does not matter once the immediate replaces it.
  always_comb begin
    in_rst    = (rst == RST_ENABLE);
    hazard    = id_valid && (haz1 || (haz2 && !id_use_imm));
    stall_req = hazard && !flush && !in_rst;
  end

  // ID/EX next state: flush > downstream hold > hazard bubble > normal load.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (flush) begin
      idex_d = IDEX_BUBBLE;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d = IDEX_BUBBLE;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      idex_d.valid   = id_valid;
      idex_d.op1     = op1_res;
      idex_d.op2     = id_use_imm ? id_imm : op2_res;
      idex_d.dest    = id_dest;
      idex_d.dest.en = id_dest.en && id_valid;
      idex_d.is_load = id_is_load;
    end
  end

  // ID/EX register and bubble counter; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (in_rst) begin
      idex_q <= IDEX_BUBBLE;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid_o   = idex_q.valid;
  assign ex_op1_o     = idex_q.op1;
  assign ex_op2_o     = idex_q.op2;
  assign ex_dest_o    = idex_q.dest;
  assign ex_is_load_o = idex_q.is_load;
  assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a forwarding instance and a non-forwarding instance
// (narrow counter) share one stimulus stream and are checked against a model
// that resolves each source by scanning in-flight producers youngest-first.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic          clk;
  reset_status_t rst;
  logic          id_valid;
  reg_info_t     id_src1;
  reg_info_t     id_src2;
  logic          id_use_imm;
  reg_data_t     id_imm;
  reg_t          id_dest;
  logic          id_is_load;
  reg_t          ex_wreg;
  logic          ex_is_load;
  reg_t          mem_wreg;
  logic          ex_stall;
  logic          flush;

  logic          stall0, stall1;
  logic          valid0, valid1;
  reg_data_t     op1_0, op1_1, op2_0, op2_1;
  reg_t          dest0, dest1;
  logic          ld0, ld1;
  logic [15:0]   cnt0;
  logic [2:0]    cnt1;

  reg_data_t     rf [32];

  int            n_asrt = 0;
  int            n_fail = 0;

  idex_t         exp_st [2];
  int            exp_cnt [2];
  int            cnt_max [2];
  logic          exp_stall [2];

  i_regbus bus0 ();
  i_regbus bus1 ();

  assign bus0.r1_data = rf[bus0.r1_info.addr];
  assign bus0.r2_data = rf[bus0.r2_info.addr];
  assign bus1.r1_data = rf[bus1.r1_info.addr];
  assign bus1.r2_data = rf[bus1.r2_info.addr];

  operand_fetch #(.FWD_EN(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_dest(id_dest), .id_is_load(id_is_load),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .mem_wreg(mem_wreg), .ex_stall(ex_stall),
    .flush(flush), .read(bus0), .stall_req(stall0), .ex_valid_o(valid0), .ex_op1_o(op1_0),
    .ex_op2_o(op2_0), .ex_dest_o(dest0), .ex_is_load_o(ld0), .lu_stall_cnt(cnt0)
  );

  operand_fetch #(.FWD_EN(1'b0), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_dest(id_dest), .id_is_load(id_is_load),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .mem_wreg(mem_wreg), .ex_stall(ex_stall),
    .flush(flush), .read(bus1), .stall_req(stall1), .ex_valid_o(valid1), .ex_op1_o(op1_1),
    .ex_op2_o(op2_1), .ex_dest_o(dest1), .ex_is_load_o(ld1), .lu_stall_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source value as the program sees it: the youngest in-flight writer of the
  // register supplies it; $0 and unused sources are zero. Without forwarding,
  // or when the youngest writer is a load still in EX, the value is unavailable.
  function automatic void model_src(input int k, input logic en, input reg_addr_t a,
                                    output reg_data_t d, output logic unavail);
    d = '0;
    unavail = 1'b0;
    if (!en || a == 0) return;
    if (ex_wreg.en && ex_wreg.addr == a) begin
      if (k == 1 || ex_is_load) unavail = 1'b1;
      else d = ex_wreg.data;
      return;
    end
    if (mem_wreg.en && mem_wreg.addr == a) begin
      if (k == 1) unavail = 1'b1;
      else d = mem_wreg.data;
      return;
    end
    d = rf[a];
  endfunction

  // One clock: predict, check the combinational stall request, clock, check state.
  task automatic step();
    idex_t     nx [2];
    reg_data_t d1, d2;
    logic      u1, u2, haz;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_src(k, id_valid & id_src1.en, id_src1.addr, d1, u1);
      model_src(k, id_valid & id_src2.en, id_src2.addr, d2, u2);
      if (id_use_imm) begin
        u2 = 1'b0;
        d2 = id_imm;
      end
      haz = u1 | u2;
      exp_stall[k] = haz && !flush && (rst != RST_ENABLE);
      nx[k] = exp_st[k];
      if (rst == RST_ENABLE) begin
        nx[k] = '0;
        exp_cnt[k] = 0;
      end else if (flush) begin
        nx[k] = '0;
      end else if (ex_stall) begin
        nx[k] = exp_st[k];
      end else if (haz) begin
        nx[k] = '0;
        if (exp_cnt[k] < cnt_max[k]) exp_cnt[k] = exp_cnt[k] + 1;
      end else begin
        nx[k].valid   = id_valid;
        nx[k].op1     = d1;
        nx[k].op2     = d2;
        nx[k].dest    = '{en: id_dest.en & id_valid, addr: id_dest.addr, data: id_dest.data};
        nx[k].is_load = id_is_load;
      end
    end
    chk("stall_req_fwd", 128'(stall0), 128'(exp_stall[0]));
    chk("stall_req_nofwd", 128'(stall1), 128'(exp_stall[1]));
    @(posedge clk);
    #1;
    exp_st[0] = nx[0];
    exp_st[1] = nx[1];
    chk("idex_fwd", 128'({valid0, op1_0, op2_0, dest0, ld0}), 128'(exp_st[0]));
    chk("idex_nofwd", 128'({valid1, op1_1, op2_1, dest1, ld1}), 128'(exp_st[1]));
    chk("cnt_fwd", 128'(cnt0), 128'(exp_cnt[0]));
    chk("cnt_nofwd", 128'(cnt1), 128'(exp_cnt[1]));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_0000;
    rf[5] = 32'h0000_1234;
    cnt_max[0] = 65535;
    cnt_max[1] = 7;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    exp_st[0] = '0;
    exp_st[1] = '0;
    rst = RST_ENABLE;
    id_valid = 1'b0;
    id_src1 = '0;
    id_src2 = '0;
    id_use_imm = 1'b0;
    id_imm = '0;
    id_dest = '0;
    id_is_load = 1'b0;
    ex_wreg = '0;
    ex_is_load = 1'b0;
    mem_wreg = '0;
    ex_stall = 1'b0;
    flush = 1'b0;

    step();
    step();
    chk("reset_valid", 128'(valid0), 128'(1'b0));
    chk("reset_cnt", 128'(cnt0), 128'(16'd0));
    rst = RST_DISABLE;

    // Plain regfile read.
    id_valid = 1'b1;
    id_src1 = '{en: 1'b1, addr: 5'd5};
    id_dest = '{en: 1'b1, addr: 5'd2, data: 32'h0};
    step();
    chk("rf_read_op1", 128'(op1_0), 128'(32'h1234));
    chk("rf_read_valid", 128'(valid0), 128'(1'b1));

    // EX and MEM both write r5: EX is younger.
    ex_wreg  = '{en: 1'b1, addr: 5'd5, data: 32'hAAAA};
    mem_wreg = '{en: 1'b1, addr: 5'd5, data: 32'hBBBB};
    step();
    chk("ex_priority", 128'(op1_0), 128'(32'hAAAA));

    // Load-use on src2: one bubble, then forwarded from MEM.
    id_src1 = '0;
    id_src2 = '{en: 1'b1, addr: 5'd7};
    ex_wreg = '{en: 1'b1, addr: 5'd7, data: 32'h0};
    ex_is_load = 1'b1;
    mem_wreg = '0;
    step();
    chk("loaduse_bubble", 128'(valid0), 128'(1'b0));
    chk("loaduse_cnt", 128'(cnt0), 128'(16'd1));
    ex_wreg = '0;
    ex_is_load = 1'b0;
    mem_wreg = '{en: 1'b1, addr: 5'd7, data: 32'hC0DE};
    step();
    chk("loaduse_fwd_op2", 128'(op2_0), 128'(32'hC0DE));

    // $0 never forwards; immediate replaces src2.
    mem_wreg = '0;
    ex_wreg = '{en: 1'b1, addr: 5'd0, data: 32'hFFFF};
    id_src1 = '{en: 1'b1, addr: 5'd0};
    id_src2 = '{en: 1'b1, addr: 5'd0};
    id_use_imm = 1'b1;
    id_imm = 32'h10;
    step();
    chk("zero_op1", 128'(op1_0), 128'(32'h0));
    chk("imm_op2", 128'(op2_0), 128'(32'h10));

    // Downstream hold during a hazard, then flush.
    id_use_imm = 1'b0;
    id_src2 = '0;
    id_src1 = '{en: 1'b1, addr: 5'd9};
    ex_wreg = '{en: 1'b1, addr: 5'd9, data: 32'h5};
    ex_is_load = 1'b1;
    ex_stall = 1'b1;
    step();
    step();
    step();
    chk("hold_cnt", 128'(cnt0), 128'(16'd1));
    chk("hold_op2", 128'(op2_0), 128'(32'h10));
    ex_stall = 1'b0;
    flush = 1'b1;
    step();
    chk("flush_valid", 128'(valid0), 128'(1'b0));
    flush = 1'b0;

    // Non-forwarding instance stalls on MEM match; saturate its counter; reset mid-stall.
    ex_wreg = '0;
    ex_is_load = 1'b0;
    mem_wreg = '{en: 1'b1, addr: 5'd3, data: 32'h77};
    id_src1 = '{en: 1'b1, addr: 5'd3};
    for (int i = 0; i < 9; i++) step();
    chk("sat_cnt_nofwd", 128'(cnt1), 128'(3'd7));
    rst = RST_ENABLE;
    step();
    chk("rst_mid_stall_cnt", 128'(cnt1), 128'(3'd0));
    chk("rst_mid_stall_valid", 128'(valid1), 128'(1'b0));
    rst = RST_DISABLE;

    // Randomized traffic on a small register window to provoke matches.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) < 3) ? RST_ENABLE : RST_DISABLE;
      id_valid   = ($urandom_range(0, 99) < 80);
      id_src1    = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 7))};
      id_src2    = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 7))};
      id_use_imm = ($urandom_range(0, 99) < 30);
      id_imm     = $urandom;
      id_dest    = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 31)), data: $urandom};
      id_is_load = 1'($urandom_range(0, 1));
      ex_wreg    = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 7)), data: $urandom};
      ex_is_load = ($urandom_range(0, 99) < 30);
      mem_wreg   = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 7)), data: $urandom};
      ex_stall   = ($urandom_range(0, 99) < 15);
      flush      = ($urandom_range(0, 99) < 10);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
